// File: rtl/bus_pkg.sv
// Shared constants and state encoding for the N-master bus arbiter.
package bus_pkg;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection over a request mask: lowest index, or
// first index strictly after the last-owner pointer with wrap-around.
module arb_picker
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MODE        = ARB_MODE_RR,
  parameter int MSEL_W      = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] mask,
  input  logic [MSEL_W-1:0]      ptr,
  output logic [MSEL_W-1:0]      idx,
  output logic                   valid
);

  always_comb begin
    int j;
    idx   = '0;
    valid = |mask;
    j     = 0;
    if (MODE == ARB_MODE_FIXED) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (mask[i]) idx = MSEL_W'(i);
      end
    end else begin
      // Scan farthest-first so the nearest candidate after ptr wins.
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        j = (int'(ptr) + k) % NUM_MASTERS;
        if (mask[j]) idx = MSEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter: fixed-priority or round-robin selection with
// zero-bubble handoff and optional maximum-tenure pre-emption.
//
// state       | meaning
// ARB_IDLE    | no owner, bgrant all-zero, msel keeps the last owner
// ARB_GRANTED | owner o = msel holds the bus, hold counter running
module bus_arbiter_n
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MODE        = ARB_MODE_RR,
  parameter int MAX_HOLD    = 16,
  parameter int MSEL_W      = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] breq,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [MSEL_W-1:0]      msel,
  output logic                   bus_busy
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_t               state;
  logic [CNT_W-1:0]         hold_cnt;
  logic [CNT_W-1:0]         hold_nxt;
  logic [MSEL_W-1:0]        ptr;
  logic [NUM_MASTERS-1:0]   pick_mask;
  logic [MSEL_W-1:0]        pick_idx;
  logic                     pick_valid;
  logic                     owner_req;
  logic                     preempt;
  logic                     do_load;
  logic                     do_idle;

  // While granted bgrant is onehot(owner), so masking it out leaves the rivals.
  assign pick_mask = (state == ARB_GRANTED) ? (breq & ~bgrant) : breq;
  assign owner_req = |(breq & bgrant);

  arb_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .MODE        (MODE),
    .MSEL_W      (MSEL_W)
  ) u_picker (
    .mask  (pick_mask),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Compare on the count including the current cycle so an owner gets
  // exactly MAX_HOLD granted cycles before a rival may take over.
  assign hold_nxt = (hold_cnt == CNT_W'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
  assign preempt  = (MAX_HOLD != 0) && (hold_nxt == CNT_W'(MAX_HOLD)) && pick_valid;

  always_comb begin
    do_load = 1'b0;
    do_idle = 1'b0;
    if (state == ARB_IDLE) begin
      do_load = pick_valid;
    end else if (!owner_req) begin
      do_load = pick_valid;
      do_idle = !pick_valid;
    end else begin
      do_load = preempt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ARB_IDLE;
      bgrant   <= '0;
      msel     <= '0;
      bus_busy <= 1'b0;
      hold_cnt <= '0;
      ptr      <= MSEL_W'(NUM_MASTERS - 1);
    end else if (do_load) begin
      state    <= ARB_GRANTED;
      bgrant   <= NUM_MASTERS'(1) << pick_idx;
      msel     <= pick_idx;
      ptr      <= pick_idx;
      bus_busy <= 1'b1;
      hold_cnt <= '0;
    end else if (do_idle) begin
      state    <= ARB_IDLE;
      bgrant   <= '0;
      bus_busy <= 1'b0;
      hold_cnt <= '0;
    end else if (state == ARB_GRANTED) begin
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Self-checking bench: three arbiter configurations driven by shared
// directed and randomised requests, checked against a tenure-level model.
module tb_bus_arbiter_n;

  localparam int N = 4;
  localparam int ND = 3;
  localparam int MODEP [ND] = '{0, 1, 1};
  localparam int HOLDP [ND] = '{16, 16, 4};

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] breq = '0;
  logic [N-1:0] gr [ND];
  logic [1:0]   ms [ND];
  logic         bb [ND];

  int tests = 0;
  int fails = 0;

  // model state per DUT: owner (-1 = none), msel, last-owner pointer, tenure
  int m_owner [ND];
  int m_msel  [ND];
  int m_ptr   [ND];
  int m_ten   [ND];
  bit armed = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter_n #(.NUM_MASTERS(N), .MODE(0), .MAX_HOLD(16)) u0 (
    .clk(clk), .rstn(rstn), .breq(breq), .bgrant(gr[0]), .msel(ms[0]), .bus_busy(bb[0]));
  bus_arbiter_n #(.NUM_MASTERS(N), .MODE(1), .MAX_HOLD(16)) u1 (
    .clk(clk), .rstn(rstn), .breq(breq), .bgrant(gr[1]), .msel(ms[1]), .bus_busy(bb[1]));
  bus_arbiter_n #(.NUM_MASTERS(N), .MODE(1), .MAX_HOLD(4)) u2 (
    .clk(clk), .rstn(rstn), .breq(breq), .bgrant(gr[2]), .msel(ms[2]), .bus_busy(bb[2]));

  function automatic int pick(logic [N-1:0] m, int mode, int p);
    if (mode == 0) begin
      for (int i = 0; i < N; i++) if (m[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    int o, w, ten;
    logic [N-1:0] oth;
    for (int d = 0; d < ND; d++) begin
      if (!rstn) begin
        m_owner[d] <= -1;
        m_msel[d]  <= 0;
        m_ptr[d]   <= N - 1;
        m_ten[d]   <= 0;
      end else begin
        o = m_owner[d];
        w = -1;
        if (o < 0) begin
          w = pick(breq, MODEP[d], m_ptr[d]);
        end else begin
          oth = breq & ~(N'(1) << o);
          if (!breq[o]) begin
            w = pick(oth, MODEP[d], m_ptr[d]);
            if (w < 0) m_owner[d] <= -1;
          end else begin
            ten = m_ten[d] + 1;
            m_ten[d] <= ten;
            if (HOLDP[d] != 0 && ten >= HOLDP[d]) w = pick(oth, MODEP[d], m_ptr[d]);
          end
        end
        if (w >= 0) begin
          m_owner[d] <= w;
          m_msel[d]  <= w;
          m_ptr[d]   <= w;
          m_ten[d]   <= 0;
        end
      end
    end
    if (!rstn) armed <= 1'b1;
  end

  always @(negedge clk) begin
    logic [N-1:0] eg;
    if (armed) begin
      for (int d = 0; d < ND; d++) begin
        eg = (m_owner[d] >= 0) ? (N'(1) << m_owner[d]) : '0;
        chk($sformatf("model_bgrant[%0d]", d), 32'(gr[d]), 32'(eg));
        chk($sformatf("model_msel[%0d]", d), 32'(ms[d]), 32'(m_msel[d]));
        chk($sformatf("model_busy[%0d]", d), 32'(bb[d]), 32'(m_owner[d] >= 0));
        chk($sformatf("onehot0[%0d]", d), 32'($onehot0(gr[d])), 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] full;
    int o;
    full = '1;

    rstn = 1'b0; breq = '0;
    tick(2);
    chk("reset_bgrant", 32'(gr[0]), 32'h0);
    chk("reset_msel", 32'(ms[0]), 32'd0);
    chk("reset_busy", 32'(bb[0]), 32'd0);
    rstn = 1'b1;

    breq = 4'b0110;
    tick(1);
    chk("fixed_first_grant", 32'(gr[0]), 32'b0010);
    chk("fixed_first_msel", 32'(ms[0]), 32'd1);
    chk("fixed_first_busy", 32'(bb[0]), 32'd1);
    breq = 4'b0100;
    tick(1);
    chk("fixed_handoff_grant", 32'(gr[0]), 32'b0100);
    chk("fixed_handoff_msel", 32'(ms[0]), 32'd2);

    breq = '0;
    tick(1);
    chk("release_idle_grant", 32'(gr[0]), 32'h0);
    chk("release_idle_busy", 32'(bb[0]), 32'd0);
    chk("release_idle_msel", 32'(ms[0]), 32'd2);
    tick(2);
    breq = 4'b0100;
    tick(1);
    chk("idle_regrant", 32'(gr[0]), 32'b0100);
    breq = '0;
    tick(1);

    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    breq = full;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      o = i % N;
      chk($sformatf("rr_order_%0d_a", i), 32'(gr[1]), 32'(N'(1) << o));
      tick(1);
      chk($sformatf("rr_order_%0d_b", i), 32'(gr[1]), 32'(N'(1) << o));
      breq = full & ~(N'(1) << o);
      tick(1);
      breq = full;
    end
    breq = '0;
    tick(2);

    breq = 4'b0001;
    tick(1);
    chk("hold_start", 32'(gr[2]), 32'b0001);
    breq = 4'b1001;
    for (int c = 2; c <= 4; c++) begin
      tick(1);
      chk($sformatf("hold_cycle_%0d", c), 32'(gr[2]), 32'b0001);
    end
    tick(1);
    chk("hold_preempt", 32'(gr[2]), 32'b1000);
    breq = '0;
    tick(1);
    breq = 4'b0001;
    tick(21);
    chk("hold_no_rival", 32'(gr[2]), 32'b0001);
    breq = '0;
    tick(2);

    breq = 4'b0100;
    tick(1);
    chk("pre_reset_owner", 32'(gr[0]), 32'b0100);
    rstn = 1'b0;
    tick(1);
    chk("midreset_grant", 32'(gr[0]), 32'h0);
    chk("midreset_msel", 32'(ms[0]), 32'd0);
    chk("midreset_busy", 32'(bb[0]), 32'd0);
    rstn = 1'b1;
    breq = 4'b1100;
    tick(1);
    chk("rr_post_reset_grant", 32'(gr[1]), 32'b0100);
    chk("rr_post_reset_msel", 32'(ms[1]), 32'd2);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) breq[b] = ~breq[b];
      rstn = ($urandom_range(199) != 0);
      tick(1);
    end
    rstn = 1'b1;
    breq = '0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
